// File: rtl/mcpu_control_fsm.sv
// Multi-cycle main controller for the MIPS-subset CPU: a Moore FSM that sequences
// every datapath enable and mux select, with the branch PC write as the one Mealy term.
module mcpu_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               zero,
  output logic [STATE_W-1:0] state,
  output logic               pc_we,
  output logic               ir_we,
  output logic               mem_we,
  output logic               mem_in,
  output logic               reg_we,
  output logic [1:0]         dst,
  output logic [1:0]         reg_in,
  output logic               a_we,
  output logic               b_we,
  output logic               ben_we,
  output logic               imm_zext,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [2:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               bne_beq,
  output logic               illegal,
  output logic               instr_done
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = STATE_W'(0),
    S_DECODE    = STATE_W'(1),
    S_MEM_ADDR  = STATE_W'(2),
    S_MEM_READ  = STATE_W'(3),
    S_MEM_WB    = STATE_W'(4),
    S_MEM_WRITE = STATE_W'(5),
    S_EXEC_R    = STATE_W'(6),
    S_R_WB      = STATE_W'(7),
    S_EXEC_I    = STATE_W'(8),
    S_I_WB      = STATE_W'(9),
    S_BRANCH    = STATE_W'(10),
    S_JUMP      = STATE_W'(11),
    S_JAL       = STATE_W'(12),
    S_JR        = STATE_W'(13)
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_bits;

  assign op          = instruction[31:26];
  assign funct       = instruction[5:0];
  assign unused_bits = ^instruction[25:6];
  assign state       = state_q;

  // Unsupported encodings map back to FETCH, which is also how DECODE flags them illegal.
  function automatic state_t decode_target(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_LW, OP_SW:     return S_MEM_ADDR;
      OP_RTYPE: begin
        case (f)
          FN_JR:                  return S_JR;
          FN_ADD, FN_SUB, FN_SLT: return S_EXEC_R;
          default:                return S_FETCH;
        endcase
      end
      OP_ADDI, OP_XORI: return S_EXEC_I;
      OP_BEQ, OP_BNE:   return S_BRANCH;
      OP_J:             return S_JUMP;
      OP_JAL:           return S_JAL;
      default:          return S_FETCH;
    endcase
  endfunction

  function automatic logic [2:0] r_aluop(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d    = S_FETCH;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    mem_in     = 1'b0;
    reg_we     = 1'b0;
    dst        = 2'd0;
    reg_in     = 2'd0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    ben_we     = 1'b0;
    imm_zext   = 1'b0;
    alusrca    = 2'd0;
    alusrcb    = 2'd0;
    aluop      = ALU_ADD;
    pcsrc      = 2'd0;
    bne_beq    = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        alusrcb = 2'd3;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_we    = 1'b1;
        b_we    = 1'b1;
        ben_we  = 1'b1;
        state_d = decode_target(op, funct);
        illegal = (state_d == S_FETCH);
      end
      S_MEM_ADDR: begin
        alusrca = 2'd1;
        alusrcb = 2'd1;
        state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_in  = 1'b1;
        alusrca = 2'd1;
        alusrcb = 2'd1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        dst        = 2'd1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_in     = 1'b1;
        mem_we     = 1'b1;
        alusrca    = 2'd1;
        alusrcb    = 2'd1;
        instr_done = 1'b1;
      end
      S_EXEC_R: begin
        alusrca = 2'd1;
        alusrcb = 2'd2;
        aluop   = r_aluop(funct);
        state_d = S_R_WB;
      end
      S_R_WB: begin
        reg_we     = 1'b1;
        reg_in     = 2'd1;
        alusrca    = 2'd1;
        alusrcb    = 2'd2;
        aluop      = r_aluop(funct);
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alusrca  = 2'd1;
        alusrcb  = 2'd1;
        imm_zext = (op == OP_XORI);
        aluop    = (op == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_d  = S_I_WB;
      end
      S_I_WB: begin
        reg_we     = 1'b1;
        dst        = 2'd1;
        reg_in     = 2'd1;
        alusrca    = 2'd1;
        alusrcb    = 2'd1;
        imm_zext   = (op == OP_XORI);
        aluop      = (op == OP_XORI) ? ALU_XOR : ALU_ADD;
        instr_done = 1'b1;
      end
      // op[0] distinguishes BNE from BEQ; the PC write tracks zero within the cycle.
      S_BRANCH: begin
        alusrca    = 2'd1;
        alusrcb    = 2'd2;
        aluop      = ALU_SUB;
        pcsrc      = 2'd1;
        bne_beq    = op[0];
        pc_we      = zero ^ op[0];
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = 2'd2;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pcsrc      = 2'd2;
        pc_we      = 1'b1;
        reg_we     = 1'b1;
        dst        = 2'd2;
        reg_in     = 2'd2;
        instr_done = 1'b1;
      end
      S_JR: begin
        pcsrc      = 2'd3;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    // An instruction interrupted by reset must not write anything further.
    if (reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      a_we       = 1'b0;
      b_we       = 1'b0;
      ben_we     = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Bench for mcpu_control_fsm: directed instructions plus random ones, compared each cycle
// against a table-driven model of per-instruction state paths and per-state control words.
module tb_mcpu_control_fsm;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       mem_we;
    logic       mem_in;
    logic       reg_we;
    logic [1:0] dst;
    logic [1:0] reg_in;
    logic       a_we;
    logic       b_we;
    logic       ben_we;
    logic       imm_zext;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       bne_beq;
    logic       illegal;
    logic       instr_done;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic [3:0]  state;
  logic        pc_we, ir_we, mem_we, mem_in, reg_we;
  logic [1:0]  dst, reg_in;
  logic        a_we, b_we, ben_we, imm_zext;
  logic [1:0]  alusrca, alusrcb;
  logic [2:0]  aluop;
  logic [1:0]  pcsrc;
  logic        bne_beq, illegal, instr_done;

  ctl_t obs;
  ctl_t row [16];
  int   path [$];
  int   checks = 0;
  int   errors = 0;

  logic [5:0] ops [10] = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h0e, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};
  logic [5:0] fns [5]  = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h01};

  always #5 clk = ~clk;

  mcpu_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero), .state(state),
    .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .mem_in(mem_in), .reg_we(reg_we),
    .dst(dst), .reg_in(reg_in), .a_we(a_we), .b_we(b_we), .ben_we(ben_we),
    .imm_zext(imm_zext), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsrc(pcsrc), .bne_beq(bne_beq), .illegal(illegal), .instr_done(instr_done)
  );

  assign obs = {pc_we, ir_we, mem_we, mem_in, reg_we, dst, reg_in, a_we, b_we, ben_we,
                imm_zext, alusrca, alusrcb, aluop, pcsrc, bne_beq, illegal, instr_done};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [8:0] enables(input ctl_t c);
    return {c.pc_we, c.ir_we, c.mem_we, c.reg_we, c.a_we, c.b_we, c.ben_we, c.illegal, c.instr_done};
  endfunction

  // Fixed control word of each state as listed in the state table.
  task automatic init_rows();
    ctl_t r;
    for (int i = 0; i < 16; i++) row[i] = '0;
    r = '0; r.ir_we = 1; r.pc_we = 1; r.alusrcb = 3;                          row[0]  = r;
    r = '0; r.a_we = 1; r.b_we = 1; r.ben_we = 1;                             row[1]  = r;
    r = '0; r.alusrca = 1; r.alusrcb = 1;                                     row[2]  = r;
    r = '0; r.mem_in = 1; r.alusrca = 1; r.alusrcb = 1;                       row[3]  = r;
    r = '0; r.reg_we = 1; r.dst = 1; r.instr_done = 1;                        row[4]  = r;
    r = '0; r.mem_in = 1; r.mem_we = 1; r.alusrca = 1; r.alusrcb = 1;
    r.instr_done = 1;                                                         row[5]  = r;
    r = '0; r.alusrca = 1; r.alusrcb = 2;                                     row[6]  = r;
    r = '0; r.reg_we = 1; r.reg_in = 1; r.alusrca = 1; r.alusrcb = 2;
    r.instr_done = 1;                                                         row[7]  = r;
    r = '0; r.alusrca = 1; r.alusrcb = 1;                                     row[8]  = r;
    r = '0; r.reg_we = 1; r.dst = 1; r.reg_in = 1; r.alusrca = 1; r.alusrcb = 1;
    r.instr_done = 1;                                                         row[9]  = r;
    r = '0; r.alusrca = 1; r.alusrcb = 2; r.aluop = 1; r.pcsrc = 1;
    r.instr_done = 1;                                                         row[10] = r;
    r = '0; r.pcsrc = 2; r.pc_we = 1; r.instr_done = 1;                       row[11] = r;
    r = '0; r.pcsrc = 2; r.pc_we = 1; r.reg_we = 1; r.dst = 2; r.reg_in = 2;
    r.instr_done = 1;                                                         row[12] = r;
    r = '0; r.pcsrc = 3; r.pc_we = 1; r.instr_done = 1;                       row[13] = r;
  endtask

  // Sequence of state codes an instruction walks through, from FETCH on.
  task automatic plan(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    path = '{0, 1};
    case (op)
      6'h23: path = '{0, 1, 2, 3, 4};
      6'h2b: path = '{0, 1, 2, 5};
      6'h00: if (fn == 6'h08) path = '{0, 1, 13};
             else if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a) path = '{0, 1, 6, 7};
      6'h08, 6'h0e: path = '{0, 1, 8, 9};
      6'h04, 6'h05: path = '{0, 1, 10};
      6'h02: path = '{0, 1, 11};
      6'h03: path = '{0, 1, 12};
      default: ;
    endcase
  endtask

  function automatic ctl_t expect_ctl(input int st, input logic [31:0] ins, input logic z, input logic bad);
    ctl_t r;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    r  = row[st];
    if (st == 1 && bad) r.illegal = 1;
    if (st == 6 || st == 7) r.aluop = (fn == 6'h22) ? 3'd1 : (fn == 6'h2a) ? 3'd3 : 3'd0;
    if ((st == 8 || st == 9) && op == 6'h0e) begin
      r.aluop    = 3'd2;
      r.imm_zext = 1;
    end
    if (st == 10) begin
      r.bne_beq = op[0];
      r.pc_we   = z ^ op[0];
    end
    return r;
  endfunction

  // zmode 0/1 fixes zero for the whole instruction, 2 randomizes it per cycle.
  task automatic run_instr(input logic [31:0] ins, input string name, input int zmode);
    logic bad;
    plan(ins);
    bad = (path.size() == 2);
    instruction = ins;
    for (int i = 0; i < path.size(); i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      check($sformatf("%s state step%0d", name, i), 32'(state), 32'(path[i]));
      check($sformatf("%s ctl st%0d", name, path[i]), 32'(obs), 32'(expect_ctl(path[i], ins, zero, bad)));
      if (path[i] == 10) begin
        zero = ~zero;
        #1;
        check($sformatf("%s ctl st10 zero toggled", name), 32'(obs), 32'(expect_ctl(10, ins, zero, bad)));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] ins, rnd;
    logic [5:0]  op, fn;
    init_rows();
    reset       = 1;
    instruction = 32'h0;
    zero        = 0;

    repeat (3) begin
      @(negedge clk);
      check("reset enables", 32'(enables(obs)), 32'd0);
      check("reset state", 32'(state), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 0;

    run_instr(32'h8C220004, "lw", 2);
    run_instr(32'h00221822, "sub", 2);
    run_instr(32'h10220003, "beq_z1", 1);
    run_instr(32'h14220003, "bne_z1", 1);
    run_instr(32'h10220003, "beq_z0", 0);
    run_instr(32'h0C000010, "jal", 2);
    run_instr(32'h03E00008, "jr", 2);
    run_instr(32'hFC000000, "ill_op3f", 2);
    run_instr(32'h00000001, "ill_fn01", 2);
    run_instr(32'h38220005, "xori", 2);
    run_instr(32'h20220005, "addi", 2);
    run_instr(32'hAC220004, "sw", 2);
    run_instr(32'h08000010, "j", 2);
    run_instr(32'h0022182A, "slt", 2);

    // Abandon an R-type in EXEC_R with reset held for three cycles.
    instruction = 32'h00221822;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1;
    @(negedge clk);
    check("midrst in exec_r", 32'(state), 32'd6);
    check("midrst enables c0", 32'(enables(obs)), 32'd0);
    for (int c = 1; c < 3; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("midrst state c%0d", c), 32'(state), 32'd0);
      check($sformatf("midrst enables c%0d", c), 32'(enables(obs)), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 0;
    run_instr(32'h8C220004, "lw_after_rst", 2);

    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
      rnd = $urandom();
      ins = {op, rnd[25:6], fn};
      run_instr(ins, $sformatf("rnd%0d_%h", n, ins), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcpu_control_fsm.md
Name: mcpu_control_fsm

Overview:
- Multi-cycle main controller for the MIPS-subset CPU.
- Consumes the instruction word held in the IR and the ALU zero flag.
- Drives every write enable and mux select in the datapath, one state per cycle.
- Replaces the combinational decode/LUT stage with an explicit Moore FSM; the branch PC write is the only Mealy output.

Parameters:
- STATE_W, 4, width of the state register and the state output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instruction  in  32  IR contents: op=[31:26], funct=[5:0].
- zero  in  1  ALU zero flag.
- state  out  STATE_W  current state code, for debug and bench.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- mem_we  out  1  memory write enable.
- mem_in  out  1  memory address select: 0=PC, 1=alu_reg.
- reg_we  out  1  regfile write enable.
- dst  out  2  write register select: 0=rd, 1=rt, 2=r31.
- reg_in  out  2  regfile write data select: 0=MDR, 1=alu_reg, 2=PC.
- a_we, b_we  out  1  A/B operand register enables.
- ben_we  out  1  branch-target register enable.
- imm_zext  out  1  1 = zero-extend imm16 (XORI), 0 = sign-extend.
- alusrca  out  2  ALU A select: 0=PC, 1=A, 2=ben, 3=0.
- alusrcb  out  2  ALU B select: 0=sext(imm)<<2, 1=ext(imm), 2=B, 3=4.
- aluop  out  3  ALU command: ADD=0, SUB=1, XOR=2, SLT=3.
- pcsrc  out  2  PC input select: 0=alu_out, 1=ben, 2={PC[31:28],addr26,2'b00}, 3=A.
- bne_beq  out  1  0=BEQ, 1=BNE; follows op[0] in BRANCH, 0 elsewhere.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- Reset: while reset=1, all enables, illegal and instr_done are forced to 0. The cycle after reset deasserts, state=FETCH. This also applies when reset is asserted mid-instruction; partially executed instructions are abandoned with no further writes.
- Defaults in every state: all enables=0, selects=0, aluop=ADD, unless listed below.
- State codes and actions:
  - FETCH(0): ir_we=1, mem_in=0, alusrca=0, alusrcb=3, pc_we=1, pcsrc=0 (PC<=PC+4). Next state: DECODE.
  - DECODE(1): a_we=b_we=1, ben_we=1, alusrca=0, alusrcb=0 (ben<=PC+4+off<<2).
  - MEM_ADDR(2): alusrca=1, alusrcb=1, ADD. Next: LW->MEM_READ, SW->MEM_WRITE.
  - MEM_READ(3): mem_in=1; ALU selects held as in MEM_ADDR. Next: MEM_WB.
  - MEM_WB(4): reg_we=1, dst=1, reg_in=0, instr_done=1. Next: FETCH.
  - MEM_WRITE(5): mem_in=1, mem_we=1, selects held as in MEM_ADDR, instr_done=1. Next: FETCH.
  - EXEC_R(6): alusrca=1, alusrcb=2; aluop from funct: 0x20 ADD, 0x22 SUB, 0x2a SLT. Next: R_WB.
  - R_WB(7): reg_we=1, dst=0, reg_in=1, selects held, instr_done=1. Next: FETCH.
  - EXEC_I(8): alusrca=1, alusrcb=1; ADDI: aluop=ADD, imm_zext=0; XORI: aluop=XOR, imm_zext=1. Next: I_WB.
  - I_WB(9): reg_we=1, dst=1, reg_in=1, selects and imm_zext held, instr_done=1. Next: FETCH.
  - BRANCH(10): alusrca=1, alusrcb=2, aluop=SUB, pcsrc=1, pc_we=zero XOR bne_beq (combinational on zero), instr_done=1. Next: FETCH.
  - JUMP(11): pcsrc=2, pc_we=1, instr_done=1. Next: FETCH.
  - JAL(12): pcsrc=2, pc_we=1, reg_we=1, dst=2, reg_in=2. r31 receives PC+4 (PC value before the edge). instr_done=1. Next: FETCH.
  - JR(13): pcsrc=3, pc_we=1, instr_done=1. Next: FETCH.
- DECODE dispatch on op:
  - 0x23 LW / 0x2b SW -> MEM_ADDR.
  - 0x00 -> funct 0x08 JR; 0x20/0x22/0x2a -> EXEC_R; other funct -> illegal.
  - 0x08 ADDI / 0x0e XORI -> EXEC_I.
  - 0x04 BEQ / 0x05 BNE -> BRANCH.
  - 0x02 J -> JUMP; 0x03 JAL -> JAL.
  - Any other op -> illegal.
- Illegal path: illegal=1 during DECODE, next state FETCH, no register, memory or PC writes beyond the FETCH PC+4.
- Codes 14–15 are unreachable; if entered, they behave as illegal and go to FETCH.
- Cycle counts: LW 5; SW/R/I 4; BEQ/BNE/J/JAL/JR 3; illegal 2.
- instruction is sampled combinationally each state; the IR is stable after FETCH.

Test Plan:
- Reset held 3 cycles mid-EXEC_R, then released -> state=0 next cycle; reg_we never asserted; FETCH shows ir_we=pc_we=1, alusrcb=3.
- LW 0x8C220004 -> states 0,1,2,3,4; MEM_WB has reg_we=1, dst=1, reg_in=0; instr_done only in state 4.
- R-type SUB, funct 0x22 -> states 0,1,6,7; aluop=1 in states 6 and 7; R_WB has dst=0, reg_in=1.
- BEQ with zero=1 -> pc_we=1, pcsrc=1 in state 10. BNE with zero=1 -> pc_we=0, bne_beq=1. Toggling zero within state 10 toggles pc_we in the same cycle.
- JAL 0x0C000010 -> states 0,1,12; state 12 has pc_we=1, pcsrc=2, reg_we=1, dst=2, reg_in=2. JR (op 0, funct 0x08) -> state 13, pcsrc=3.
- Opcode 0x3F, and op 0 with funct 0x01 -> illegal=1 in DECODE, next state 0, mem_we=reg_we=0 throughout. XORI -> imm_zext=1 and aluop=2 in states 8–9.
